rs_alu_seq: RTL

RS_ALU_SEQ -- requirements
Module: rs_alu_seq

---
 rtl/rs_alu_seq_pkg.sv | 13 +
 rtl/rs_alu_seq_slice.sv | 23 ++
 rtl/rs_alu_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rs_alu_seq_pkg.sv
// Shared types and default sizing for the chunk-serial add/subtract unit.
package rs_alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_CHUNK_W = 16;
  localparam int DEF_NWORDS  = 4;

endpackage

// File: rtl/rs_alu_seq_slice.sv
// CHUNK_W-bit adder slice; the one adder the sequencer reuses for every chunk.
module rs_alu_seq_slice
  import rs_alu_seq_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s,
  output logic               co,
  output logic               c_msb_in
);

  logic [CHUNK_W:0] full_s;

  assign full_s = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, ci};
  assign s      = full_s[CHUNK_W-1:0];
  assign co     = full_s[CHUNK_W];
  // The MSB sum bit is a^b^carry_in, so the carry into it falls out without a second adder.
  assign c_msb_in = s[CHUNK_W-1] ^ a[CHUNK_W-1] ^ b[CHUNK_W-1];

endmodule

// File: rtl/rs_alu_seq.sv
// Chunk-serial OP_W-bit add/subtract: one CHUNK_W slice per RUN cycle, LSB chunk first.
// Optional abort input enabled by defining RS_ALU_SEQ_ABORT_EN.
module rs_alu_seq
  import rs_alu_seq_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int NWORDS  = DEF_NWORDS,
  localparam int OP_W   = CHUNK_W * NWORDS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic            op_sub,
  input  logic            cin,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
`ifdef RS_ALU_SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [OP_W-1:0] result,
  output logic            cout,
  output logic            overflow
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  state_e            state_r;
  state_e            state_next_s;
  logic [IDX_W-1:0]  idx_r;
  logic              carry_r;
  logic [OP_W-1:0]   a_r;
  logic [OP_W-1:0]   b_r;
  logic [OP_W-1:0]   result_r;
  logic              cout_r;
  logic              overflow_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;

  logic              accept_s;
  logic              step_s;
  logic              last_s;
  logic              abort_s;
  logic [CHUNK_W-1:0] a_chunk_s;
  logic [CHUNK_W-1:0] b_chunk_s;
  logic [CHUNK_W-1:0] sum_s;
  logic              co_s;
  logic              c_msb_s;

`ifdef RS_ALU_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign last_s    = (idx_r == IDX_LAST);
  assign a_chunk_s = a_r[int'(idx_r) * CHUNK_W +: CHUNK_W];
  assign b_chunk_s = b_r[int'(idx_r) * CHUNK_W +: CHUNK_W];

  rs_alu_seq_slice #(
    .CHUNK_W (CHUNK_W)
  ) u_slice (
    .a        (a_chunk_s),
    .b        (b_chunk_s),
    .ci       (carry_r),
    .s        (sum_s),
    .co       (co_s),
    .c_msb_in (c_msb_s)
  );

  // Next-state decode; abort only has an effect while a chunk walk is in progress.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_valid) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_next_s = ST_IDLE;
        end else if (last_s) begin
          state_next_s = ST_DONE;
          step_s       = 1'b1;
        end else begin
          state_next_s = ST_RUN;
          step_s       = 1'b1;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register plus registered handshake/status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == ST_IDLE);
      busy_r  <= (state_next_s == ST_RUN);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture and chunk walk; subtract is A + ~B + 1, so B is inverted on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r      <= '0;
      carry_r    <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      result_r   <= '0;
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      idx_r   <= '0;
      carry_r <= op_sub ? 1'b1 : cin;
      a_r     <= a;
      b_r     <= op_sub ? ~b : b;
    end else if (step_s) begin
      result_r[int'(idx_r) * CHUNK_W +: CHUNK_W] <= sum_s;
      carry_r <= co_s;
      if (last_s) begin
        idx_r      <= '0;
        cout_r     <= co_s;
        overflow_r <= c_msb_s ^ co_s;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  assign start_ready = ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign cout        = cout_r;
  assign overflow    = overflow_r;

endmodule
